// File: rtl/alu.sv
// Y86-64 OPq ALU: combinational result, registered ZF/SF/OF condition codes.
// Define ALU_CARRY_EN to add a registered carry/borrow flag output cf.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
`ifdef ALU_CARRY_EN
  output logic             cf,
`endif
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  logic z_n, s_n, o_n;
`ifdef ALU_CARRY_EN
  logic c_n;
`endif

  always_comb begin
    y   = '0;
    o_n = 1'b0;
`ifdef ALU_CARRY_EN
    c_n = 1'b0;
`endif
    case (control)
      2'b01: begin
`ifdef ALU_CARRY_EN
        // Bit WIDTH of the widened difference is the unsigned borrow.
        {c_n, y} = {1'b0, a} - {1'b0, b};
`else
        y = a - b;
`endif
        o_n = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
      end
      2'b10: y = a & b;
      2'b11: y = a ^ b;
      default: begin
`ifdef ALU_CARRY_EN
        {c_n, y} = {1'b0, a} + {1'b0, b};
`else
        y = a + b;
`endif
        o_n = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
    endcase
    z_n = (y == '0);
    s_n = y[MSB];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (set_cc) begin
      zf <= z_n;
      sf <= s_n;
      of <= o_n;
    end
  end

`ifdef ALU_CARRY_EN
  always_ff @(posedge clk) begin
    if (reset)       cf <= 1'b0;
    else if (set_cc) cf <= c_n;
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed literal cases plus randomized ops against an
// arithmetic reference model, checked every cycle on the falling edge.
module tb_alu;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    control;
  logic [W-1:0]  a, b;
  logic          set_cc;
  logic [W-1:0]  y;
  logic          zf, sf, of;
`ifdef ALU_CARRY_EN
  logic          cf;
`endif

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .control(control), .a(a), .b(b), .set_cc(set_cc),
`ifdef ALU_CARRY_EN
    .cf(cf),
`endif
    .y(y), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  // Reference model: results from plain integer arithmetic.
  function automatic logic [W-1:0] ref_y(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] z);
    case (c)
      2'b00:   return x + z;
      2'b01:   return x - z;
      2'b10:   return x & z;
      default: return x ^ z;
    endcase
  endfunction

  // Overflow: the exact signed result does not fit in W bits.
  function automatic logic ref_of(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] z);
    logic signed [W:0] exact, fit;
    logic [W-1:0] r;
    r   = ref_y(c, x, z);
    fit = $signed({r[W-1], r});
    if (c == 2'b00)      exact = $signed({x[W-1], x}) + $signed({z[W-1], z});
    else if (c == 2'b01) exact = $signed({x[W-1], x}) - $signed({z[W-1], z});
    else                 return 1'b0;
    return exact != fit;
  endfunction

  function automatic logic ref_cf(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, z};
    if (c == 2'b00) return s[W];
    if (c == 2'b01) return x < z;
    return 1'b0;
  endfunction

  logic ez, es, eo, ec, mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      ez <= 1'b1; es <= 1'b0; eo <= 1'b0; ec <= 1'b0; mvalid <= 1'b1;
    end else if (set_cc) begin
      ez <= (ref_y(control, a, b) == '0);
      es <= $signed(ref_y(control, a, b)) < 0;
      eo <= ref_of(control, a, b);
      ec <= ref_cf(control, a, b);
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] ey;
    ey = ref_y(control, a, b);
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL model_y t=%0t ctl=%0d got=%h exp=%h", $time, control, y, ey);
    end
    if (mvalid) begin
      checks++;
      if ({zf, sf, of} !== {ez, es, eo}) begin
        errors++;
        $display("FAIL model_flags t=%0t got zso=%b%b%b exp=%b%b%b", $time, zf, sf, of, ez, es, eo);
      end
`ifdef ALU_CARRY_EN
      checks++;
      if (cf !== ec) begin
        errors++;
        $display("FAIL model_cf t=%0t got=%b exp=%b", $time, cf, ec);
      end
`endif
    end
  end

  task automatic drive(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] z,
                       input logic s, input logic r);
    @(posedge clk);
    #1;
    control = c; a = x; b = z; set_cc = s; reset = r;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [W-1:0] ey, input logic [2:0] ezso);
    checks++;
    if (y !== ey || {zf, sf, of} !== ezso) begin
      errors++;
      $display("FAIL %s got y=%h zso=%b%b%b exp y=%h zso=%b", name, y, zf, sf, of, ey, ezso);
    end
  endtask

  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] DEAD = 64'hDEAD_BEEF_0000_1234;

  initial begin
    reset = 1'b1; set_cc = 1'b0; control = 2'b00; a = '0; b = '0;
    drive(2'b00, 64'd5, 64'd3, 1'b0, 1'b0);
    lit("add_noset", 64'd8, 3'b100);
    drive(2'b01, 64'd3, 64'd5, 1'b1, 1'b0);
    lit("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 3'b100);
    drive(2'b00, MAXP, 64'd1, 1'b1, 1'b0);
    lit("add_ovf", MINN, 3'b010);
`ifdef ALU_CARRY_EN
    checks++;
    if (cf !== 1'b1) begin errors++; $display("FAIL cf_borrow got=%b exp=1", cf); end
`endif
    drive(2'b11, DEAD, DEAD, 1'b1, 1'b0);
    lit("xor_zero", 64'd0, 3'b011);
    drive(2'b01, MINN, 64'd1, 1'b1, 1'b0);
    lit("sub_wrap", MAXP, 3'b100);
    drive(2'b10, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0);
    lit("and_hold", 64'h00F0, 3'b001);
    drive(2'b01, MINN, 64'd1, 1'b1, 1'b1);
    lit("reset_vs_set", MAXP, 3'b001);
    drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
    lit("reset_wins", 64'd0, 3'b100);

    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] x, z;
      x = {$urandom, $urandom};
      z = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: x = MAXP;
        1: x = MINN;
        2: z = x;
        3: z = 64'd1;
        default: ;
      endcase
      drive(2'($urandom_range(0, 3)), x, z, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
